// File: rtl/retire_trace_buffer.sv
// Retire trace buffer.
// Captures each retired instruction from the core into a small record FIFO
// and drains the head record as six 32-bit words over a valid/ready stream.
// Records lost to a full FIFO are counted and reported in the next header.
module retire_trace_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     en_i,
   input  logic                     update_i,
   input  logic [XLEN-1:0]          pc_i,
   input  logic [XLEN-1:0]          instr_i,
   input  logic [4:0]               reg_addr_i,
   input  logic [XLEN-1:0]          reg_data_i,
   input  logic [XLEN-1:0]          mem_addr_i,
   input  logic [XLEN-1:0]          mem_data_i,
   input  logic                     mem_wrt_i,
   output logic                     trace_valid_o,
   output logic [XLEN-1:0]          trace_data_o,
   output logic                     trace_last_o,
   input  logic                     trace_ready_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = 6 * XLEN;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   // Record layout: word k of the stream lives at rec[k*XLEN +: XLEN].
   function automatic logic [XLEN-1:0] word_sel(input logic [RW-1:0] rec,
                                                input logic [2:0]    idx);
      logic [XLEN-1:0] w;
      case (idx)
         3'd0:    w = rec[0*XLEN +: XLEN];
         3'd1:    w = rec[1*XLEN +: XLEN];
         3'd2:    w = rec[2*XLEN +: XLEN];
         3'd3:    w = rec[3*XLEN +: XLEN];
         3'd4:    w = rec[4*XLEN +: XLEN];
         3'd5:    w = rec[5*XLEN +: XLEN];
         default: w = {XLEN{1'b0}};
      endcase
      return w;
   endfunction

   // Header word: sync byte, sequence number, drops preceding this record,
   // memory-write flag and destination register.
   function automatic logic [XLEN-1:0] build_header(input logic [7:0] seq,
                                                    input logic [7:0] drop,
                                                    input logic       wrt,
                                                    input logic [4:0] addr);
      return {8'hA5, seq, drop, 2'b00, wrt, addr};
   endfunction

   logic [RW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [7:0]      r_seq;
   logic [7:0]      r_drop;
   logic            r_overflow;
   logic [0:0]      r_state;
   logic [2:0]      r_word_idx;
   logic            r_valid;
   logic            r_last;
   logic [XLEN-1:0] r_data;

   logic            w_full;
   logic            w_req;
   logic            w_hs;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic [AW-1:0]   w_rptr_nxt;
   logic [CW-1:0]   w_count_nxt;
   logic [RW-1:0]   w_new_rec;
   logic [RW-1:0]   w_next_rec;

   // Push/pop/drop decisions and next FIFO occupancy.
   always_comb begin
      w_full     = (r_count == CW'(DEPTH));
      w_req      = en_i & update_i;
      w_hs       = r_valid & trace_ready_i;
      w_pop      = w_hs & (r_word_idx == 3'd5);
      w_push     = w_req & (~w_full | w_pop);
      w_drop     = w_req & w_full & ~w_pop;
      w_rptr_nxt = r_rptr + AW'(1);
      w_new_rec  = {mem_data_i, mem_addr_i, reg_data_i, instr_i, pc_i,
                    build_header(r_seq, r_drop, mem_wrt_i, reg_addr_i)};
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
      // With a single record held, the next head is the one being written
      // this cycle and is not yet in storage, so forward it from the inputs.
      if (r_count == CW'(1)) begin
         w_next_rec = w_new_rec;
      end else begin
         w_next_rec = r_mem[w_rptr_nxt];
      end
   end

   // Record storage write; no reset needed since occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (rstn_i && w_push) begin
         r_mem[r_wptr] <= w_new_rec;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= w_rptr_nxt;
         end
         r_count <= w_count_nxt;
      end
   end

   // Sequence number, drop counter and sticky overflow flag.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_seq      <= 8'd0;
         r_drop     <= 8'd0;
         r_overflow <= 1'b0;
      end else if (w_push) begin
         r_seq  <= r_seq + 8'd1;
         r_drop <= 8'd0;
      end else if (w_drop) begin
         if (r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
         end
         r_overflow <= 1'b1;
      end
   end

   // Stream FSM: presents the head record word by word, registered outputs.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state    <= ST_IDLE;
         r_word_idx <= 3'd0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_data     <= {XLEN{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_word_idx <= 3'd0;
               r_last     <= 1'b0;
               if (r_count != CW'(0)) begin
                  r_state <= ST_STREAM;
                  r_valid <= 1'b1;
                  r_data  <= word_sel(r_mem[r_rptr], 3'd0);
               end else begin
                  r_valid <= 1'b0;
                  r_data  <= {XLEN{1'b0}};
               end
            end
            ST_STREAM: begin
               if (w_hs) begin
                  if (r_word_idx == 3'd5) begin
                     r_word_idx <= 3'd0;
                     r_last     <= 1'b0;
                     if (w_count_nxt != CW'(0)) begin
                        r_data <= word_sel(w_next_rec, 3'd0);
                     end else begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_data  <= {XLEN{1'b0}};
                     end
                  end else begin
                     r_word_idx <= r_word_idx + 3'd1;
                     r_last     <= (r_word_idx == 3'd4);
                     r_data     <= word_sel(r_mem[r_rptr], r_word_idx + 3'd1);
                  end
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_word_idx <= 3'd0;
               r_valid    <= 1'b0;
               r_last     <= 1'b0;
               r_data     <= {XLEN{1'b0}};
            end
         endcase
      end
   end

   assign trace_valid_o = r_valid;
   assign trace_data_o  = r_data;
   assign trace_last_o  = r_last;
   assign count_o       = r_count;
   assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: a reference model at the
// falling edge predicts every stream word, valid, count and overflow.
module tb_retire_trace_buffer;

   localparam int XLEN  = 32;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rstn_i;
   logic            en_i;
   logic            update_i;
   logic [31:0]     pc_i;
   logic [31:0]     instr_i;
   logic [4:0]      reg_addr_i;
   logic [31:0]     reg_data_i;
   logic [31:0]     mem_addr_i;
   logic [31:0]     mem_data_i;
   logic            mem_wrt_i;
   logic            trace_valid_o;
   logic [31:0]     trace_data_o;
   logic            trace_last_o;
   logic            trace_ready_i;
   logic [CW-1:0]   count_o;
   logic            overflow_o;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t        sb_q[$];
   int          m_count = 0;
   logic [7:0]  m_seq   = 8'd0;
   logic [7:0]  m_drop  = 8'd0;
   logic        m_ovf   = 1'b0;
   logic        m_valid = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rstn_i        (rstn_i),
      .en_i          (en_i),
      .update_i      (update_i),
      .pc_i          (pc_i),
      .instr_i       (instr_i),
      .reg_addr_i    (reg_addr_i),
      .reg_data_i    (reg_data_i),
      .mem_addr_i    (mem_addr_i),
      .mem_data_i    (mem_data_i),
      .mem_wrt_i     (mem_wrt_i),
      .trace_valid_o (trace_valid_o),
      .trace_data_o  (trace_data_o),
      .trace_last_o  (trace_last_o),
      .trace_ready_i (trace_ready_i),
      .count_o       (count_o),
      .overflow_o    (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Compare current outputs with the model, then advance the model by the
   // coming rising edge using the inputs that edge will sample.
   task automatic model_step();
      logic pop;
      logic cap;
      logic drp;
      int   new_count;
      exp_t e;
      check_val("valid", 32'(trace_valid_o), 32'(m_valid));
      check_val("count", 32'(count_o), m_count);
      check_val("overflow", 32'(overflow_o), 32'(m_ovf));
      pop = 1'b0;
      if (m_valid) begin
         check_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q[0];
            check_val("data", trace_data_o, e.data);
            check_val("last", 32'(trace_last_o), 32'(e.last));
            if (trace_ready_i) begin
               void'(sb_q.pop_front());
               pop = e.last;
            end
         end
      end else begin
         check_val("last_idle", 32'(trace_last_o), 32'd0);
      end
      if (!rstn_i) begin
         sb_q.delete();
         m_count = 0;
         m_seq   = 8'd0;
         m_drop  = 8'd0;
         m_ovf   = 1'b0;
         m_valid = 1'b0;
      end else begin
         cap = en_i && update_i && ((m_count < DEPTH) || pop);
         drp = en_i && update_i && (m_count == DEPTH) && !pop;
         if (cap) begin
            sb_q.push_back('{{8'hA5, m_seq, m_drop, 2'b00, mem_wrt_i, reg_addr_i}, 1'b0});
            sb_q.push_back('{pc_i, 1'b0});
            sb_q.push_back('{instr_i, 1'b0});
            sb_q.push_back('{reg_data_i, 1'b0});
            sb_q.push_back('{mem_addr_i, 1'b0});
            sb_q.push_back('{mem_data_i, 1'b1});
            m_seq  = m_seq + 8'd1;
            m_drop = 8'd0;
         end
         if (drp) begin
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            m_ovf = 1'b1;
         end
         new_count = m_count + (cap ? 1 : 0) - (pop ? 1 : 0);
         if (m_valid) m_valid = !(pop && new_count == 0);
         else         m_valid = (m_count != 0);
         m_count = new_count;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         model_step();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rec();
      pc_i       = $urandom;
      instr_i    = $urandom;
      reg_addr_i = 5'($urandom);
      reg_data_i = $urandom;
      mem_addr_i = $urandom;
      mem_data_i = $urandom;
      mem_wrt_i  = 1'($urandom);
   endtask

   task automatic set_plain_rec();
      set_rec();
      reg_addr_i = 5'd0;
      mem_wrt_i  = 1'b0;
   endtask

   task automatic do_reset();
      rstn_i   = 1'b0;
      update_i = 1'b0;
      en_i     = 1'b1;
      tick();
      rstn_i = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         if (m_count == 0 && !m_valid && sb_q.size() == 0) done = 1'b1;
         else tick();
      end
      check_val("drain_timeout", 32'(done), 32'd1);
   endtask

   task automatic capture_one();
      update_i = 1'b1;
      tick();
      update_i = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      rstn_i = 1'b0; en_i = 1'b1; update_i = 1'b0; trace_ready_i = 1'b0;
      pc_i = 32'd0; instr_i = 32'd0; reg_addr_i = 5'd0; reg_data_i = 32'd0;
      mem_addr_i = 32'd0; mem_data_i = 32'd0; mem_wrt_i = 1'b0;

      // Reset state and a single record
      do_reset();
      check_val("rst_data", trace_data_o, 32'd0);
      check_val("rst_last", 32'(trace_last_o), 32'd0);
      check_val("rst_count", 32'(count_o), 32'd0);
      trace_ready_i = 1'b1;
      pc_i = 32'h8000_0000; instr_i = 32'h0010_0093; reg_addr_i = 5'd1; reg_data_i = 32'd1;
      mem_addr_i = 32'd0; mem_data_i = 32'd0; mem_wrt_i = 1'b0;
      capture_one();
      tick();
      check_val("single_w0_valid", 32'(trace_valid_o), 32'd1);
      check_val("single_w0", trace_data_o, 32'hA500_0001);
      wait_drain(50);
      check_val("single_count_end", 32'(count_o), 32'd0);

      // Back-pressure: ready toggles every cycle
      do_reset();
      trace_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_rec();
         update_i = 1'b1;
         trace_ready_i = ~trace_ready_i;
         tick();
      end
      update_i = 1'b0;
      for (int i = 0; i < 200 && (m_count != 0 || m_valid); i++) begin
         trace_ready_i = ~trace_ready_i;
         tick();
      end
      trace_ready_i = 1'b1;
      wait_drain(50);

      // Overflow: 11 updates into 8 slots with the sink stalled
      do_reset();
      trace_ready_i = 1'b0;
      for (int i = 0; i < 11; i++) begin
         set_rec();
         capture_one();
      end
      check_val("ovf_count", 32'(count_o), 32'd8);
      check_val("ovf_flag", 32'(overflow_o), 32'd1);
      trace_ready_i = 1'b1;
      wait_drain(200);
      set_plain_rec();
      capture_one();
      tick();
      check_val("ovf_next_hdr", trace_data_o, 32'hA508_0300);
      wait_drain(50);

      // Push in the same cycle the last word of a full FIFO is accepted
      do_reset();
      trace_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_rec();
         capture_one();
      end
      check_val("full_count", 32'(count_o), 32'd8);
      trace_ready_i = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (trace_last_o) found = 1'b1;
         else tick();
      end
      check_val("full_found_last", 32'(found), 32'd1);
      set_rec();
      capture_one();
      check_val("full_pushpop_count", 32'(count_o), 32'd8);
      check_val("full_pushpop_ovf", 32'(overflow_o), 32'd0);
      wait_drain(200);

      // Sequence wrap, then updates with capture disabled
      do_reset();
      trace_ready_i = 1'b1;
      for (int i = 0; i < 257; i++) begin
         set_rec();
         capture_one();
         repeat (5) tick();
      end
      en_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_rec();
         capture_one();
      end
      en_i = 1'b1;
      wait_drain(50);
      set_plain_rec();
      capture_one();
      tick();
      check_val("wrap_next_hdr", trace_data_o, 32'hA501_0000);
      wait_drain(50);

      // Reset after W2 is accepted
      do_reset();
      trace_ready_i = 1'b1;
      set_rec();
      capture_one();
      repeat (4) tick();
      rstn_i = 1'b0;
      tick();
      rstn_i = 1'b1;
      check_val("midrst_valid", 32'(trace_valid_o), 32'd0);
      check_val("midrst_count", 32'(count_o), 32'd0);
      set_plain_rec();
      capture_one();
      tick();
      check_val("midrst_hdr", trace_data_o, 32'hA500_0000);
      wait_drain(50);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Sits directly downstream of the single-cycle core's retire port.
- Captures every retired instruction (update/pc/instr/reg/mem fields) into a record FIFO.
- Drains records as a 6-word 32-bit stream over a valid/ready interface to a trace sink (UART bridge, testbench scoreboard, debug DMA).
- Counts records lost to overflow and reports the count in-band.

Parameters:
XLEN, 32, width of all retire data fields and of the trace word; only 32 is supported.
DEPTH, 8, record FIFO depth in records; power of two, >= 2.

Ports:
clk_i  input  1  system clock
rstn_i  input  1  reset, synchronous, active-low
en_i  input  1  capture enable; when 0, update_i is ignored and not counted as a drop
update_i  input  1  retire strobe from core, one record per cycle when high
pc_i  input  XLEN  retired PC
instr_i  input  XLEN  retired instruction
reg_addr_i  input  5  retired destination register (0 = none)
reg_data_i  input  XLEN  retired register write data
mem_addr_i  input  XLEN  retired memory address
mem_data_i  input  XLEN  retired memory write data
mem_wrt_i  input  1  retired memory write enable
trace_valid_o  output  1  stream word valid
trace_data_o  output  XLEN  stream word
trace_last_o  output  1  high on word 5 (last word of record)
trace_ready_i  input  1  sink accepts word when valid and ready are both high
count_o  output  $clog2(DEPTH)+1  records currently held, including the one being streamed
overflow_o  output  1  sticky: at least one record dropped since reset

Behaviour:
- Reset (rstn_i low at posedge) values: FIFO empty, count_o=0, trace_valid_o=0, trace_last_o=0, trace_data_o=0, overflow_o=0, seq=0, drop_cnt=0, word_idx=0, FSM=IDLE. Reset mid-stream abandons the partial record; no further words are emitted.
- Capture: at a posedge with en_i=1, update_i=1 and the FIFO not full, all input fields are written to the tail.
  - The header fields seq and drop_cnt are frozen into the record at this edge.
  - Then seq increments, mod 256 (255 -> 0), and drop_cnt clears to 0.
- Drop: at a posedge with en_i=1, update_i=1, the FIFO full and no pop in the same cycle:
  - The record is discarded.
  - drop_cnt increments, saturating at 255.
  - overflow_o is set.
  - seq is not incremented.
- Simultaneous push and pop when full: a push in the same cycle that word 5 is accepted succeeds; count_o is unchanged.
- Stream word order for the head record:
  - W0 header = {8'hA5, seq[7:0], drop_cnt[7:0], 2'b00, mem_wrt, reg_addr[4:0]}
  - W1 pc, W2 instr, W3 reg_data, W4 mem_addr, W5 mem_data.
- FSM:
  - IDLE: trace_valid_o=0. Go to STREAM with word_idx=0 on the cycle after count becomes nonzero.
  - STREAM: trace_valid_o=1 and trace_data_o = word[word_idx]. A handshake advances word_idx.
  - A handshake on word_idx=5 pops the head and resets word_idx to 0. The FSM stays in STREAM if another record remains, otherwise goes to IDLE.
- Latency: a record captured at edge N has W0 valid after edge N+1 when the buffer was empty. Back-to-back records stream with no idle cycle between W5 and the next W0.
- Handshake rules:
  - While trace_valid_o=1 and trace_ready_i=0, trace_data_o and trace_last_o hold stable.
  - trace_valid_o never drops without a handshake, except on reset.
- trace_last_o = trace_valid_o and (word_idx==5).
- count_o is updated at the edge of a push or pop; push and pop in the same cycle leave it unchanged.
- Outputs are driven from registers or the FIFO head only; there is no combinational path from trace_ready_i to trace_valid_o.

Test Plan:
- Single record: pc=0x8000_0000, instr=0x0010_0093, reg_addr=1, reg_data=1, trace_ready_i=1.
  - Expected: 6 consecutive words.
  - W0=0xA500_0001, W1=0x8000_0000, W2=0x0010_0093, W3=1; trace_last_o only on W5; count_o returns to 0.
- Back-pressure: 3 records captured, trace_ready_i toggled 1/0 every cycle.
  - Expected: 18 words in order, data stable during every ready=0 cycle, seq fields 0, 1, 2.
- Overflow: DEPTH=8, trace_ready_i=0, 11 consecutive updates.
  - Expected: count_o=8 and overflow_o=1.
  - Then ready=1: 8 records streamed with drop field 0; the next captured record header carries seq=8, drop_cnt=3.
- Full push/pop: FIFO full, update_i=1 in the cycle W5 is accepted.
  - Expected: count_o stays 8 and no drop is counted.
- Sequence wrap and enable: 257 records captured with ready=1, then 4 updates with en_i=0.
  - Expected: seq goes 0..255, 0; en_i=0 updates produce no records and drop_cnt stays 0.
- Reset mid-stream: rstn_i low for 1 cycle after W2 is accepted.
  - Expected: trace_valid_o=0 and count_o=0 next cycle; the next record's W0 shows seq=0.
